// File: rtl/i2c_expander_pkg.sv
// Shared types and constants for the emulated PCA9555-style I2C port expander.
// Register indices match the pointer values the I2C initiator sends.
package i2c_expander_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } state_t;

    localparam logic [2:0] REG_IN0  = 3'd0;
    localparam logic [2:0] REG_IN1  = 3'd1;
    localparam logic [2:0] REG_OUT0 = 3'd2;
    localparam logic [2:0] REG_OUT1 = 3'd3;
    localparam logic [2:0] REG_INV0 = 3'd4;
    localparam logic [2:0] REG_INV1 = 3'd5;
    localparam logic [2:0] REG_CFG0 = 3'd6;
    localparam logic [2:0] REG_CFG1 = 3'd7;

    localparam logic [7:0] OUT_RST = 8'hFF;
    localparam logic [7:0] INV_RST = 8'h00;
    localparam logic [7:0] CFG_RST = 8'hFF;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus glitch filter for one I2C line.
// A new level is accepted after FILTER_CYCLES consecutive equal synchronised samples.
module i2c_line_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic i_clk48,
    input  logic i_reset_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [3:0] LAST_COUNT = 4'(FILTER_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic [3:0] r_cnt;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;

    // Idle bus is high, so everything resets to the released level.
    always_ff @(posedge i_clk48 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= 4'd0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= 4'd0;
            end else if (r_cnt == LAST_COUNT) begin
                r_cnt   <= 4'd0;
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_fall  <= !r_sync2;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_expander_target.sv
// I2C target emulating a 16-bit PCA9555-style expander: pointer/register-pair
// writes and reads, input inversion, direction config and input-change interrupt.
module i2c_expander_target
    import i2c_expander_pkg::*;
#(
    parameter logic [6:0] ADDRESS       = 7'h24,
    parameter int         FILTER_CYCLES = 4
) (
    input  logic        clk48,
    input  logic        reset_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] port_in,
    output logic [15:0] port_out,
    output logic [15:0] port_dir,
    output logic        int_n
);

    logic w_scl, w_sclRise, w_sclFall;
    logic w_sda, w_sdaRise, w_sdaFall;
    logic w_start, w_stop, w_load, w_wrEn;
    logic [15:0] w_inVal;
    logic [7:0]  w_rdByte;
    logic [1:0]  w_diff;

    state_t      r_state;
    logic [3:0]  r_bitCnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_tx;
    logic        r_rw;
    logic        r_ack;
    logic [2:0]  r_ptr;
    logic        r_sdaOe;
    logic [15:0] r_out;
    logic [15:0] r_inv;
    logic [15:0] r_cfg;
    logic [15:0] r_snap;
    logic [1:0]  r_pend;

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sclFilter (
        .i_clk48   (clk48),
        .i_reset_n (reset_n),
        .i_line    (scl_i),
        .o_level   (w_scl),
        .o_rise    (w_sclRise),
        .o_fall    (w_sclFall)
    );

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sdaFilter (
        .i_clk48   (clk48),
        .i_reset_n (reset_n),
        .i_line    (sda_i),
        .o_level   (w_sda),
        .o_rise    (w_sdaRise),
        .o_fall    (w_sdaFall)
    );

    assign w_start = w_sdaFall && w_scl;
    assign w_stop  = w_sdaRise && w_scl;
    assign w_inVal = port_in ^ r_inv;

    // A read byte is loaded on the falling edge that closes an address or data ACK.
    assign w_load = w_sclFall && !w_start && !w_stop &&
                    (((r_state == ST_ADDR_ACK) && r_rw) ||
                     ((r_state == ST_RDATA_ACK) && r_ack));
    assign w_wrEn = (r_state == ST_WDATA_ACK) && w_sclRise && !w_start && !w_stop;

    always_comb begin
        w_rdByte = 8'h00;
        case (r_ptr)
            REG_IN0:  w_rdByte = w_inVal[7:0];
            REG_IN1:  w_rdByte = w_inVal[15:8];
            REG_OUT0: w_rdByte = r_out[7:0];
            REG_OUT1: w_rdByte = r_out[15:8];
            REG_INV0: w_rdByte = r_inv[7:0];
            REG_INV1: w_rdByte = r_inv[15:8];
            REG_CFG0: w_rdByte = r_cfg[7:0];
            REG_CFG1: w_rdByte = r_cfg[15:8];
            default:  w_rdByte = 8'h00;
        endcase
    end

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_bitCnt <= 4'd0;
            r_shift  <= 8'h00;
            r_tx     <= 8'h00;
            r_rw     <= 1'b0;
            r_ack    <= 1'b0;
            r_ptr    <= 3'd0;
            r_sdaOe  <= 1'b0;
        end else if (w_start) begin
            r_state  <= ST_ADDR;
            r_bitCnt <= 4'd0;
            r_sdaOe  <= 1'b0;
        end else if (w_stop) begin
            r_state  <= ST_IDLE;
            r_bitCnt <= 4'd0;
            r_sdaOe  <= 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (w_sclRise && (r_bitCnt != 4'd8)) begin
                        r_shift  <= {r_shift[6:0], w_sda};
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end else if (w_sclFall && (r_bitCnt == 4'd8)) begin
                        r_bitCnt <= 4'd0;
                        if (r_state == ST_ADDR) begin
                            if (r_shift[7:1] == ADDRESS) begin
                                r_state <= ST_ADDR_ACK;
                                r_rw    <= r_shift[0];
                                r_sdaOe <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else if (r_state == ST_PTR) begin
                            r_state <= ST_PTR_ACK;
                            r_sdaOe <= 1'b1;
                        end else begin
                            r_state <= ST_WDATA_ACK;
                            r_sdaOe <= 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK, ST_RDATA_ACK: begin
                    if (w_sclRise) begin
                        r_ack <= !w_sda;
                    end
                    if (w_load) begin
                        r_state  <= ST_RDATA;
                        r_sdaOe  <= !w_rdByte[7];
                        r_tx     <= {w_rdByte[6:0], 1'b0};
                        r_ptr[0] <= !r_ptr[0];
                        r_bitCnt <= 4'd0;
                    end else if (w_sclFall) begin
                        r_state <= (r_state == ST_ADDR_ACK) ? ST_PTR : ST_IDLE;
                        r_sdaOe <= 1'b0;
                    end
                end
                ST_PTR_ACK: begin
                    if (w_sclRise) begin
                        r_ptr <= r_shift[2:0];
                    end else if (w_sclFall) begin
                        r_state <= ST_WDATA;
                        r_sdaOe <= 1'b0;
                    end
                end
                ST_WDATA_ACK: begin
                    if (w_sclRise) begin
                        r_ptr[0] <= !r_ptr[0];
                    end else if (w_sclFall) begin
                        r_state <= ST_WDATA;
                        r_sdaOe <= 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (w_sclRise) begin
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end else if (w_sclFall) begin
                        if (r_bitCnt == 4'd8) begin
                            r_state  <= ST_RDATA_ACK;
                            r_sdaOe  <= 1'b0;
                            r_bitCnt <= 4'd0;
                        end else begin
                            r_sdaOe <= !r_tx[7];
                            r_tx    <= {r_tx[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sdaOe <= 1'b0;
                end
            endcase
        end
    end

    // Writes to the input pair are acknowledged but land nowhere.
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= {OUT_RST, OUT_RST};
            r_inv <= {INV_RST, INV_RST};
            r_cfg <= {CFG_RST, CFG_RST};
        end else if (w_wrEn) begin
            case (r_ptr)
                REG_OUT0: r_out[7:0]  <= r_shift;
                REG_OUT1: r_out[15:8] <= r_shift;
                REG_INV0: r_inv[7:0]  <= r_shift;
                REG_INV1: r_inv[15:8] <= r_shift;
                REG_CFG0: r_cfg[7:0]  <= r_shift;
                REG_CFG1: r_cfg[15:8] <= r_shift;
                default:  ;
            endcase
        end
    end

    assign w_diff[0] = |((port_in[7:0]  ^ r_snap[7:0])  & r_cfg[7:0]);
    assign w_diff[1] = |((port_in[15:8] ^ r_snap[15:8]) & r_cfg[15:8]);

    // Pending tracks input-vs-snapshot difference; loading the input byte re-arms it.
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            r_snap <= 16'h0000;
            r_pend <= 2'b00;
        end else begin
            if (w_load && (r_ptr == REG_IN0)) begin
                r_snap[7:0] <= port_in[7:0];
                r_pend[0]   <= 1'b0;
            end else begin
                r_pend[0] <= w_diff[0];
            end
            if (w_load && (r_ptr == REG_IN1)) begin
                r_snap[15:8] <= port_in[15:8];
                r_pend[1]    <= 1'b0;
            end else begin
                r_pend[1] <= w_diff[1];
            end
        end
    end

    assign sda_oe   = r_sdaOe;
    assign port_out = r_out;
    assign port_dir = r_cfg;
    assign int_n    = !(r_pend[0] || r_pend[1]);

endmodule

// File: tb/tb_i2c_expander_target.sv
// Self-checking bench: bit-banged I2C initiator on an open-drain SDA model,
// with a register-level reference model of the expander.
module tb_i2c_expander_target;

    localparam logic [6:0] ADDR = 7'h24;
    localparam int FILT = 4;
    localparam int Q = 10;

    logic        clk48 = 1'b0;
    logic        reset_n;
    logic        scl;
    logic        mSda;
    logic        sdaLine;
    logic        sda_oe;
    logic [15:0] port_in;
    logic [15:0] port_out;
    logic [15:0] port_dir;
    logic        int_n;

    int checks = 0;
    int errors = 0;
    logic sawOe;
    logic [7:0] mReg [8];
    int mPtr;

    assign sdaLine = mSda & ~sda_oe;

    always #5 clk48 = ~clk48;

    always @(posedge clk48) begin
        if (sda_oe === 1'b1) sawOe = 1'b1;
    end

    i2c_expander_target #(.ADDRESS(ADDR), .FILTER_CYCLES(FILT)) dut (
        .clk48    (clk48),
        .reset_n  (reset_n),
        .scl_i    (scl),
        .sda_i    (sdaLine),
        .sda_oe   (sda_oe),
        .port_in  (port_in),
        .port_out (port_out),
        .port_dir (port_dir),
        .int_n    (int_n)
    );

    // Reference model: eight byte registers; the pointer steps within its pair.
    task automatic mdlReset();
        mReg[0] = 8'h00; mReg[1] = 8'h00;
        mReg[2] = 8'hFF; mReg[3] = 8'hFF;
        mReg[4] = 8'h00; mReg[5] = 8'h00;
        mReg[6] = 8'hFF; mReg[7] = 8'hFF;
        mPtr = 0;
    endtask

    function automatic int pairNext(int p);
        return (p % 2 == 0) ? p + 1 : p - 1;
    endfunction

    function automatic logic [7:0] mdlRead(int idx);
        if (idx == 0) return port_in[7:0] ^ mReg[4];
        if (idx == 1) return port_in[15:8] ^ mReg[5];
        return mReg[idx];
    endfunction

    task automatic mdlWrite(input logic [7:0] ptrByte, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] d [3];
        int p;
        d[0] = d0; d[1] = d1; d[2] = d2;
        p = int'(ptrByte) % 8;
        for (int k = 0; k < n; k++) begin
            if (p >= 2) mReg[p] = d[k];
            p = pairNext(p);
        end
        mPtr = p;
    endtask

    // Bus-level initiator.
    task automatic waitClk(input int n);
        repeat (n) @(posedge clk48);
    endtask

    task automatic i2cStart();
        mSda = 1'b1; waitClk(Q);
        scl = 1'b1;  waitClk(Q);
        mSda = 1'b0; waitClk(Q);
        scl = 1'b0;  waitClk(Q);
    endtask

    task automatic i2cStop();
        mSda = 1'b0; waitClk(Q);
        scl = 1'b1;  waitClk(Q);
        mSda = 1'b1; waitClk(2 * Q);
    endtask

    task automatic writeBit(input logic b);
        mSda = b;   waitClk(Q);
        scl = 1'b1; waitClk(2 * Q);
        scl = 1'b0; waitClk(Q);
    endtask

    task automatic readBit(output logic b);
        mSda = 1'b1; waitClk(Q);
        scl = 1'b1;  waitClk(Q);
        @(negedge clk48);
        b = sdaLine;
        waitClk(Q);
        scl = 1'b0;  waitClk(Q);
    endtask

    task automatic writeByte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        readBit(b);
        acked = !b;
    endtask

    task automatic readByte(input logic giveAck, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            d[i] = b;
        end
        writeBit(!giveAck);
    endtask

    task automatic i2cWrite(input logic [6:0] addr, input logic [7:0] ptrByte, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            output int acks);
        logic a;
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        acks = 0;
        i2cStart();
        writeByte({addr, 1'b0}, a); acks += int'(a);
        writeByte(ptrByte, a);      acks += int'(a);
        for (int k = 0; k < n; k++) begin
            writeByte(d[k], a);
            acks += int'(a);
        end
        i2cStop();
    endtask

    task automatic i2cRead(input logic [7:0] ptrByte, input int n,
                           output logic [7:0] r0, output logic [7:0] r1,
                           output int acks, output logic released);
        logic a;
        acks = 0;
        r1 = 8'h00;
        i2cStart();
        writeByte({ADDR, 1'b0}, a); acks += int'(a);
        writeByte(ptrByte, a);      acks += int'(a);
        i2cStart();
        writeByte({ADDR, 1'b1}, a); acks += int'(a);
        if (n == 2) begin
            readByte(1'b1, r0);
            readByte(1'b0, r1);
        end else begin
            readByte(1'b0, r0);
        end
        @(negedge clk48);
        released = (sda_oe === 1'b0);
        i2cStop();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; scl = 1'b1; mSda = 1'b1; port_in = 16'h0000;
        mdlReset();
        waitClk(5);
        @(negedge clk48);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        reset_n = 1'b1;
        waitClk(Q);
        @(negedge clk48);
        checks++; if (port_out !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_port_out: got %h expected ffff", port_out); end
        checks++; if (port_dir !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_port_dir: got %h expected ffff", port_dir); end
        checks++; if (int_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_int_n: got %b expected 1", int_n); end
    endtask

    task automatic test_write_config();
        int acks;
        i2cWrite(ADDR, 8'h06, 2, 8'hC0, 8'hDF, 8'h00, acks);
        mdlWrite(8'h06, 2, 8'hC0, 8'hDF, 8'h00);
        checks++; if (acks != 4) begin errors++; $display("[TB] FAIL cfg_acks: got %0d expected 4", acks); end
        checks++; if (port_dir !== 16'hDFC0) begin errors++; $display("[TB] FAIL cfg_port_dir: got %h expected dfc0", port_dir); end
    endtask

    task automatic test_write_output();
        int acks;
        i2cWrite(ADDR, 8'h02, 2, 8'h3F, 8'h00, 8'h00, acks);
        mdlWrite(8'h02, 2, 8'h3F, 8'h00, 8'h00);
        checks++; if (port_out !== 16'h003F) begin errors++; $display("[TB] FAIL out_pair: got %h expected 003f", port_out); end
        i2cWrite(ADDR, 8'h02, 3, 8'h01, 8'h02, 8'h03, acks);
        mdlWrite(8'h02, 3, 8'h01, 8'h02, 8'h03);
        checks++; if (acks != 5) begin errors++; $display("[TB] FAIL out_wrap_acks: got %0d expected 5", acks); end
        checks++; if (port_out !== 16'h0203) begin errors++; $display("[TB] FAIL out_wrap: got %h expected 0203", port_out); end
    endtask

    task automatic test_read();
        int acks;
        logic [7:0] r0, r1;
        logic rel;
        i2cWrite(ADDR, 8'h04, 2, 8'h0F, 8'h00, 8'h00, acks);
        mdlWrite(8'h04, 2, 8'h0F, 8'h00, 8'h00);
        port_in = 16'hA55A;
        i2cRead(8'h00, 2, r0, r1, acks, rel);
        checks++; if (acks != 3) begin errors++; $display("[TB] FAIL read_acks: got %0d expected 3", acks); end
        checks++; if (r0 !== 8'h55) begin errors++; $display("[TB] FAIL read_in0: got %h expected 55", r0); end
        checks++; if (r1 !== 8'hA5) begin errors++; $display("[TB] FAIL read_in1: got %h expected a5", r1); end
        checks++; if (rel !== 1'b1) begin errors++; $display("[TB] FAIL read_nack_release: got sda_oe %b expected 0", sda_oe); end
    endtask

    task automatic test_wrong_address();
        int acks;
        sawOe = 1'b0;
        i2cWrite(7'h25, 8'h02, 1, 8'h11, 8'h00, 8'h00, acks);
        checks++; if (acks != 0) begin errors++; $display("[TB] FAIL wrong_addr_acks: got %0d expected 0", acks); end
        checks++; if (sawOe !== 1'b0) begin errors++; $display("[TB] FAIL wrong_addr_sda_oe: got %b expected 0", sawOe); end
        checks++; if (port_out !== {mReg[3], mReg[2]}) begin errors++; $display("[TB] FAIL wrong_addr_out: got %h expected %h", port_out, {mReg[3], mReg[2]}); end
        checks++; if (port_dir !== {mReg[7], mReg[6]}) begin errors++; $display("[TB] FAIL wrong_addr_dir: got %h expected %h", port_dir, {mReg[7], mReg[6]}); end
    endtask

    task automatic test_interrupt();
        int acks;
        int lat;
        logic [7:0] r0, r1;
        logic rel;
        i2cWrite(ADDR, 8'h06, 2, 8'hFF, 8'hFF, 8'h00, acks);
        mdlWrite(8'h06, 2, 8'hFF, 8'hFF, 8'h00);
        port_in = 16'($urandom);
        i2cRead(8'h00, 2, r0, r1, acks, rel);
        checks++; if (r0 !== mdlRead(0)) begin errors++; $display("[TB] FAIL int_snap_in0: got %h expected %h", r0, mdlRead(0)); end
        waitClk(5);
        @(negedge clk48);
        checks++; if (int_n !== 1'b1) begin errors++; $display("[TB] FAIL int_idle: got %b expected 1", int_n); end
        lat = -1;
        port_in[3] = ~port_in[3];
        for (int c = 1; c <= 2 + FILT + 1; c++) begin
            @(negedge clk48);
            if (int_n === 1'b0 && lat < 0) lat = c;
        end
        checks++; if (lat < 0) begin errors++; $display("[TB] FAIL int_assert: got int_n %b expected 0 within %0d clocks", int_n, 2 + FILT + 1); end
        port_in[3] = ~port_in[3];
        waitClk(5);
        @(negedge clk48);
        checks++; if (int_n !== 1'b1) begin errors++; $display("[TB] FAIL int_return: got %b expected 1", int_n); end
        port_in[3] = ~port_in[3];
        waitClk(5);
        @(negedge clk48);
        checks++; if (int_n !== 1'b0) begin errors++; $display("[TB] FAIL int_reassert: got %b expected 0", int_n); end
        i2cRead(8'h00, 1, r0, r1, acks, rel);
        checks++; if (r0 !== mdlRead(0)) begin errors++; $display("[TB] FAIL int_read_in0: got %h expected %h", r0, mdlRead(0)); end
        @(negedge clk48);
        checks++; if (int_n !== 1'b1) begin errors++; $display("[TB] FAIL int_clear_on_read: got %b expected 1", int_n); end
    endtask

    task automatic test_reset_midread();
        int acks;
        logic a, b;
        logic [7:0] r0, r1;
        logic rel;
        i2cWrite(ADDR, 8'h02, 2, 8'h00, 8'h00, 8'h00, acks);
        mdlWrite(8'h02, 2, 8'h00, 8'h00, 8'h00);
        i2cStart();
        writeByte({ADDR, 1'b0}, a);
        writeByte(8'h02, a);
        i2cStart();
        writeByte({ADDR, 1'b1}, a);
        for (int i = 0; i < 3; i++) readBit(b);
        mSda = 1'b1; waitClk(Q);
        scl = 1'b1;  waitClk(Q / 2);
        @(negedge clk48);
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("[TB] FAIL midread_drive: got %b expected 1", sda_oe); end
        port_in = 16'h0000;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_async_sda: got %b expected 0", sda_oe); end
        checks++; if (port_out !== 16'hFFFF) begin errors++; $display("[TB] FAIL midreset_out: got %h expected ffff", port_out); end
        checks++; if (port_dir !== 16'hFFFF) begin errors++; $display("[TB] FAIL midreset_dir: got %h expected ffff", port_dir); end
        checks++; if (int_n !== 1'b1) begin errors++; $display("[TB] FAIL midreset_int_n: got %b expected 1", int_n); end
        waitClk(5);
        reset_n = 1'b1;
        mdlReset();
        waitClk(2 * Q);
        i2cWrite(ADDR, 8'h02, 2, 8'hA5, 8'h5A, 8'h00, acks);
        mdlWrite(8'h02, 2, 8'hA5, 8'h5A, 8'h00);
        checks++; if (acks != 4) begin errors++; $display("[TB] FAIL post_reset_acks: got %0d expected 4", acks); end
        checks++; if (port_out !== {mReg[3], mReg[2]}) begin errors++; $display("[TB] FAIL post_reset_out: got %h expected %h", port_out, {mReg[3], mReg[2]}); end
        i2cRead(8'h02, 2, r0, r1, acks, rel);
        checks++; if ({r1, r0} !== 16'h5AA5) begin errors++; $display("[TB] FAIL post_reset_read: got %h expected 5aa5", {r1, r0}); end
    endtask

    task automatic test_random();
        int acks, n, p;
        logic [7:0] ptrByte, d0, d1, d2, r0, r1, e0, e1;
        logic rel;
        for (int it = 0; it < 6; it++) begin
            port_in = 16'($urandom);
            ptrByte = 8'($urandom);
            n  = $urandom_range(1, 3);
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
            i2cWrite(ADDR, ptrByte, n, d0, d1, d2, acks);
            mdlWrite(ptrByte, n, d0, d1, d2);
            checks++; if (acks != n + 2) begin errors++; $display("[TB] FAIL rand_acks: got %0d expected %0d", acks, n + 2); end
            checks++; if (port_out !== {mReg[3], mReg[2]}) begin errors++; $display("[TB] FAIL rand_out: got %h expected %h", port_out, {mReg[3], mReg[2]}); end
            checks++; if (port_dir !== {mReg[7], mReg[6]}) begin errors++; $display("[TB] FAIL rand_dir: got %h expected %h", port_dir, {mReg[7], mReg[6]}); end
            ptrByte = 8'($urandom);
            p  = int'(ptrByte) % 8;
            e0 = mdlRead(p);
            e1 = mdlRead(pairNext(p));
            i2cRead(ptrByte, 2, r0, r1, acks, rel);
            checks++; if (r0 !== e0) begin errors++; $display("[TB] FAIL rand_read0: got %h expected %h (reg %0d)", r0, e0, p); end
            checks++; if (r1 !== e1) begin errors++; $display("[TB] FAIL rand_read1: got %h expected %h (reg %0d)", r1, e1, pairNext(p)); end
        end
    endtask

    initial begin
        test_reset();
        test_write_config();
        test_write_output();
        test_read();
        test_wrong_address();
        test_interrupt();
        test_reset_midread();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
